// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// The controller is the master. It reads the IR fields and the ALU zero flag,
// and it drives every datapath enable and select.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_operation;
  logic [3:0] state;
  logic       instr_done;

  modport master (
    input  opcode, funct, zero,
    output pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_operation, state, instr_done
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_operation, state, instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, j, addi).
// All outputs decode combinationally from the current state plus the IR fields.
// While rst is high, every write enable and instr_done is forced low.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t     state_q, state_d;
  logic       funct_ok_q;
  logic       funct_ok_c;
  logic [2:0] funct_op_c;

  logic pc_write_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c, done_c;

  // Map the R-type funct field to an ALU code and flag the codes we support.
  always_comb begin
    funct_ok_c = 1'b1;
    funct_op_c = 3'b010;
    case (bus.funct)
      6'b100000: funct_op_c = 3'b010;
      6'b100010: funct_op_c = 3'b110;
      6'b100100: funct_op_c = 3'b000;
      6'b100101: funct_op_c = 3'b001;
      default:   funct_ok_c = 1'b0;
    endcase
  end

  // State register. Reset returns to FETCH asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Latch funct validity in EXEC so that ALUWB can suppress the write for an unknown funct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  funct_ok_q <= 1'b0;
    else if (state_q == EXEC) funct_ok_q <= funct_ok_c;
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    state_d           = FETCH;
    pc_write_c        = 1'b0;
    mem_read_c        = 1'b0;
    mem_write_c       = 1'b0;
    ir_write_c        = 1'b0;
    reg_write_c       = 1'b0;
    done_c            = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_operation = 3'b010;
    case (state_q)
      FETCH: begin
        mem_read_c    = 1'b1;
        ir_write_c    = 1'b1;
        pc_write_c    = 1'b1;
        bus.alu_src_b = 2'b01;
        state_d       = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d = FETCH;
            done_c  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord   = 1'b1;
        mem_read_c = 1'b1;
        state_d    = MEMWB;
      end
      MEMWB: begin
        reg_write_c    = 1'b1;
        bus.mem_to_reg = 1'b1;
        done_c         = 1'b1;
      end
      MEMWR: begin
        bus.iord    = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
      end
      EXEC: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_operation = funct_op_c;
        state_d           = ALUWB;
      end
      ALUWB: begin
        reg_write_c = funct_ok_q;
        bus.reg_dst = 1'b1;
        done_c      = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_operation = 3'b111;
        bus.pc_source     = 2'b01;
        pc_write_c        = bus.zero;
        done_c            = 1'b1;
      end
      JUMP: begin
        bus.pc_source = 2'b10;
        pc_write_c    = 1'b1;
        done_c        = 1'b1;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Hold every write enable low for as long as reset is asserted.
  assign bus.pc_write   = pc_write_c  & ~rst;
  assign bus.mem_read   = mem_read_c  & ~rst;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.ir_write   = ir_write_c  & ~rst;
  assign bus.reg_write  = reg_write_c & ~rst;
  assign bus.instr_done = done_c      & ~rst;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. For each instruction, the stimulus
// process queues the expected per-cycle control word. A negedge monitor then pops
// each entry and compares it against the DUT outputs.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcs;
    logic [2:0] op;
    logic       done;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   active = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic rec_t base(int st);
    rec_t r;
    r    = '0;
    r.st = st[3:0];
    r.op = 3'b010;
    return r;
  endfunction

  function automatic bit known_op(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic bit known_fn(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101};
  endfunction

  function automatic logic [2:0] fn_op(logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic rec_t sample();
    rec_t r;
    r.st   = bus.state;
    r.pcw  = bus.pc_write;   r.iord = bus.iord;     r.mrd  = bus.mem_read;
    r.mwr  = bus.mem_write;  r.irw  = bus.ir_write; r.m2r  = bus.mem_to_reg;
    r.rdst = bus.reg_dst;    r.rw   = bus.reg_write; r.srca = bus.alu_src_a;
    r.srcb = bus.alu_src_b;  r.pcs  = bus.pc_source; r.op   = bus.alu_operation;
    r.done = bus.instr_done;
    return r;
  endfunction

  // Queue one cycle's expectation, then advance to just after the next rising edge.
  task automatic push_cycle(rec_t r);
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t reset_rec();
    rec_t r;
    r      = base(0);
    r.srcb = 2'b01;
    return r;
  endfunction

  // Run one instruction from FETCH. With abort set (sw only), reset is asserted during MEMWR.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic bz, bit abort);
    rec_t r;
    bus.opcode = 6'($urandom);
    bus.funct  = 6'($urandom);
    bus.zero   = 1'($urandom);
    r = base(0); r.pcw = 1; r.mrd = 1; r.irw = 1; r.srcb = 2'b01;
    push_cycle(r);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = 1'($urandom);
    r = base(1); r.srcb = 2'b11; r.done = !known_op(op);
    push_cycle(r);
    if (!known_op(op)) return;
    bus.zero = 1'($urandom);
    case (op)
      6'b100011, 6'b101011: begin
        r = base(2); r.srca = 1; r.srcb = 2'b10;
        push_cycle(r);
        bus.zero = 1'($urandom);
        if (op == 6'b100011) begin
          r = base(3); r.iord = 1; r.mrd = 1;
          push_cycle(r);
          bus.zero = 1'($urandom);
          r = base(4); r.rw = 1; r.m2r = 1; r.done = 1;
          push_cycle(r);
        end else begin
          r = base(5); r.iord = 1; r.mwr = 1; r.done = 1;
          if (!abort) push_cycle(r);
          else begin
            q.push_back(r);
            @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_state", 32'(bus.state), 32'd0);
            check("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
            @(posedge clk);
            #1;
            push_cycle(reset_rec());
            rst = 1'b0;
          end
        end
      end
      6'b000000: begin
        r = base(6); r.srca = 1; r.op = fn_op(fn);
        push_cycle(r);
        bus.zero = 1'($urandom);
        r = base(7); r.rw = known_fn(fn); r.rdst = 1; r.done = 1;
        push_cycle(r);
      end
      6'b000100: begin
        bus.zero = bz;
        r = base(8); r.srca = 1; r.op = 3'b111; r.pcs = 2'b01; r.pcw = bz; r.done = 1;
        push_cycle(r);
      end
      6'b000010: begin
        r = base(9); r.pcs = 2'b10; r.pcw = 1; r.done = 1;
        push_cycle(r);
      end
      default: begin
        r = base(10); r.srca = 1; r.srcb = 2'b10;
        push_cycle(r);
        bus.zero = 1'($urandom);
        r = base(11); r.rw = 1; r.done = 1;
        push_cycle(r);
      end
    endcase
  endtask

  // Monitor: compare every cycle against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (active) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_underflow t=%0t actual=empty required=entry", $time);
        end else begin
          rec_t e;
          e = q.pop_front();
          check("cycle", 32'(sample()), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    bus.opcode = 6'b111111;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b1;
    for (int i = 0; i < 3; i++) push_cycle(reset_rec());
    rst = 1'b0;

    run_instr(6'b100011, 6'h00, 1'b0, 1'b0);   // lw
    run_instr(6'b000000, 6'b100010, 1'b0, 1'b0); // sub
    run_instr(6'b000100, 6'h00, 1'b1, 1'b0);   // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 1'b0);   // beq not taken
    run_instr(6'b111111, 6'h00, 1'b0, 1'b0);   // unknown opcode
    run_instr(6'b000000, 6'b000111, 1'b0, 1'b0); // unknown funct
    run_instr(6'b101011, 6'h00, 1'b0, 1'b1);   // sw aborted by reset
    run_instr(6'b000010, 6'h00, 1'b0, 1'b0);   // j
    run_instr(6'b001000, 6'h00, 1'b0, 1'b0);   // addi

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b000010;
        6: op = 6'b001000;
        default: begin
          op = 6'($urandom);
          while (known_op(op)) op = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 4))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom), 1'b0);
    end

    active = 1'b0;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the shared 32-bit ALU, register file, instruction register and unified memory of the multicycle MIPS datapath. One ALU serves PC increment, branch-target computation, address generation and execution, each in a different cycle. The block decodes opcode/funct into `alu_operation` codes the ALU accepts and uses the ALU `zero` flag to resolve `beq`.

## Interface
Parameters:
- none (encodings fixed by the ISA subset below)

Ports:
- `clk` in 1: single clock; all state changes on rising edge
- `rst` in 1: asynchronous, active-high reset
- `opcode` in 6: IR[31:26], valid from DECODE onward
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU zero flag; meaningful only when `alu_operation`=111
- `pc_write` out 1: PC load enable
- `iord` out 1: 0 = memory address from PC, 1 = from ALUOut
- `mem_read` out 1
- `mem_write` out 1
- `ir_write` out 1
- `mem_to_reg` out 1: 1 = writeback from MDR, 0 = from ALUOut
- `reg_dst` out 1: 1 = rd, 0 = rt
- `reg_write` out 1
- `alu_src_a` out 1: 0 = PC, 1 = register A
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_operation` out 3: 010 add, 110 sub, 000 and, 001 or, 111 compare (a−b, drives `zero`)
- `state` out 4: current state encoding (debug/verification)
- `instr_done` out 1: one-cycle pulse in the last state of each instruction

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are illegal and go to FETCH.
- FETCH: `mem_read`, `ir_write`, `pc_write`=1. `alu_src_a`=0, `alu_src_b`=01, op 010, `pc_source`=00. Next state DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, op 010 (branch target to ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH with no writes; `instr_done` pulses.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, op 010. lw → MEMRD; sw → MEMWR.
- MEMRD: `iord`=1, `mem_read`=1 → MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
- MEMWR: `iord`=1, `mem_write`=1 → FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00. Op by funct:
  - 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001
  - unknown funct → 010, and the following ALUWB suppresses `reg_write`.
  - Next state ALUWB.
- ALUWB: `reg_write`=1 (unless funct unknown), `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, op 111, `pc_source`=01, `pc_write`=`zero` (combinational) → FETCH.
- JUMP: `pc_source`=10, `pc_write`=1 → FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, op 010 → ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- Default value of every output not listed for a state is 0, including `alu_operation`=010 as the don't-care default.
- `instr_done`=1 in MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB, and in DECODE for an unknown opcode.

## Timing
- Only the state register and a registered copy of `funct` validity are sequential. All outputs decode combinationally from `state` plus `opcode`/`funct`/`zero`.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- Reset: `rst` high forces `state`=FETCH immediately, asynchronously. While `rst` is high, `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` and `instr_done` are held 0; other outputs show FETCH values. The first fetch occurs on the first rising edge after `rst` deasserts.
- Reset mid-instruction abandons it; no partial write is issued after the reset assertion.
- `opcode` and `funct` are sampled from IR. IR updates only at the end of FETCH, so both are stable from DECODE to instruction end.
- `zero` is used only in BRANCH. It is ignored in all other states even if high.

## Test plan
- Reset then lw (opcode 100011): `state` sequence 0,1,2,3,4,0. `iord`=1 only in states 3–4 is not correct — `iord`=1 only in state 3. `reg_write`=1 only in 4 with `mem_to_reg`=1. `instr_done` pulses once.
- R-type funct 100010 (sub): EXEC outputs `alu_operation`=110, `alu_src_a`=1. ALUWB has `reg_dst`=1, `reg_write`=1. Four cycles total.
- beq with `zero`=1 in BRANCH: `alu_operation`=111, `pc_write`=1, `pc_source`=01. Repeat with `zero`=0: `pc_write`=0. Three cycles each.
- Unknown opcode 111111: sequence 0,1,0. No write enable asserted in DECODE. `instr_done`=1 in DECODE.
- Unknown funct 000111: EXEC op 010, ALUWB `reg_write`=0, then back to FETCH.
- Assert `rst` asynchronously mid-MEMWR: `state`=0 and `mem_write`=0 within the same cycle, before the next edge. After release, FETCH behaviour resumes normally.
